// File: rtl/ballot_counter_if.sv
// Ballot counter bus: officer controls and buttons in, tallies and election result out.
interface ballot_counter_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
);
  localparam int IDX_W = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1;
  localparam int TOT_W = CNT_W + IDX_W;

  logic                      ballot_open;
  logic [NUM_CAND-1:0]       vote;
  logic                      close_polls;
  logic                      ready;
  logic                      vote_ack;
  logic                      invalid;
  logic                      overflow;
  logic [NUM_CAND*CNT_W-1:0] counts;
  logic [TOT_W-1:0]          total_votes;
  logic                      polls_closed;
  logic                      result_valid;
  logic [IDX_W-1:0]          winner;
  logic                      tie;

  modport master (
    output ballot_open, vote, close_polls,
    input  ready, vote_ack, invalid, overflow, counts, total_votes,
           polls_closed, result_valid, winner, tie
  );

  modport slave (
    input  ballot_open, vote, close_polls,
    output ready, vote_ack, invalid, overflow, counts, total_votes,
           polls_closed, result_valid, winner, tie
  );
endinterface

// File: rtl/ballot_counter.sv
// Multi-candidate ballot counter: one press per authorised ballot, saturating tallies,
// and a sequential max/tie scan of all tallies once the polls close.
//   state   | meaning
//   S_IDLE  | waiting for ballot_open
//   S_ARMED | ballot authorised, waiting for a single rising press
//   S_SCAN  | polls closed, visiting one tally per cycle
//   S_DONE  | winner/tie valid; only reset leaves
module ballot_counter #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  ballot_counter_if.slave bus
);
  localparam int IDX_W = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1;
  localparam int TOT_W = CNT_W + IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SCAN, S_DONE} state_t;

  state_t                             state_q, state_d;
  logic [NUM_CAND-1:0]                vote_q, vote_d;
  logic [NUM_CAND-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [TOT_W-1:0]                   total_q, total_d;
  logic                               ready_q, ready_d;
  logic                               ack_q, ack_d;
  logic                               inv_q, inv_d;
  logic                               ovf_q, ovf_d;
  logic                               closed_q, closed_d;
  logic                               rv_q, rv_d;
  logic [IDX_W-1:0]                   scan_idx_q, scan_idx_d;
  logic [CNT_W-1:0]                   max_q, max_d;
  logic [IDX_W-1:0]                   win_q, win_d;
  logic                               tie_q, tie_d;

  logic [NUM_CAND-1:0] press;
  logic                press_multi;
  logic [IDX_W-1:0]    press_idx;
  logic [CNT_W-1:0]    cur;

  always_comb begin
    state_d    = state_q;
    vote_d     = bus.vote;
    cnt_d      = cnt_q;
    total_d    = total_q;
    ack_d      = 1'b0;
    inv_d      = 1'b0;
    ovf_d      = ovf_q;
    scan_idx_d = scan_idx_q;
    max_d      = max_q;
    win_d      = win_q;
    tie_d      = tie_q;
    cur        = cnt_q[scan_idx_q];

    press       = bus.vote & ~vote_q;
    // Clearing the lowest set bit leaves something only if two or more were set.
    press_multi = |(press & (press - NUM_CAND'(1)));
    press_idx   = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (press[i]) press_idx = IDX_W'(i);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.close_polls) begin
          state_d    = S_SCAN;
          scan_idx_d = '0;
        end else if (bus.ballot_open) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.close_polls) begin
          state_d    = S_SCAN;
          scan_idx_d = '0;
        end else if (press_multi) begin
          inv_d = 1'b1;
        end else if (|press) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
          if (cnt_q[press_idx] == CNT_MAX) ovf_d = 1'b1;
          else cnt_d[press_idx] = cnt_q[press_idx] + CNT_W'(1);
          if (total_q == TOT_MAX) ovf_d = 1'b1;
          else total_d = total_q + TOT_W'(1);
        end
      end
      S_SCAN: begin
        if (scan_idx_q == '0) begin
          max_d = cur;
          win_d = '0;
          tie_d = 1'b0;
        end else if (cur > max_q) begin
          max_d = cur;
          win_d = scan_idx_q;
          tie_d = 1'b0;
        end else if (cur == max_q) begin
          tie_d = 1'b1;
        end
        if (scan_idx_q == IDX_W'(NUM_CAND - 1)) state_d = S_DONE;
        else scan_idx_d = scan_idx_q + IDX_W'(1);
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    ready_d  = (state_d == S_ARMED);
    closed_d = (state_d == S_SCAN) || (state_d == S_DONE);
    rv_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vote_q     <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
      closed_q   <= 1'b0;
      rv_q       <= 1'b0;
      scan_idx_q <= '0;
      max_q      <= '0;
      win_q      <= '0;
      tie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vote_q     <= vote_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      inv_q      <= inv_d;
      ovf_q      <= ovf_d;
      closed_q   <= closed_d;
      rv_q       <= rv_d;
      scan_idx_q <= scan_idx_d;
      max_q      <= max_d;
      win_q      <= win_d;
      tie_q      <= tie_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.vote_ack     = ack_q;
  assign bus.invalid      = inv_q;
  assign bus.overflow     = ovf_q;
  assign bus.counts       = cnt_q;
  assign bus.total_votes  = total_q;
  assign bus.polls_closed = closed_q;
  assign bus.result_valid = rv_q;
  assign bus.winner       = win_q;
  assign bus.tie          = tie_q;
endmodule

// File: doc/ballot_counter.md
# ballot_counter

Parametrised multi-candidate ballot counter with a per-voter session state machine. Each vote must be authorised by a presiding-officer `ballot_open` pulse, and each authorised ballot accepts exactly one button press. Counters saturate, and on `close_polls` the block scans all tallies to report a winner and a tie flag. It sits between debounced candidate buttons and the result display, replacing the free-running per-button counters.

## Interface
Parameters:
- `NUM_CAND`, default 4: number of candidates, 2..16.
- `CNT_W`, default 8: width of each per-candidate tally.
- Derived `IDX_W` = max(1, $clog2(NUM_CAND)). Derived `TOT_W` = CNT_W + IDX_W.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `ballot_open`, in, 1: pulse; authorises one ballot.
- `vote`, in, NUM_CAND: level button inputs; bit i selects candidate i.
- `close_polls`, in, 1: pulse; ends voting and starts the result scan.
- `ready`, out, 1: a ballot is armed and waiting for a press.
- `vote_ack`, out, 1: one-cycle pulse; a vote was recorded.
- `invalid`, out, 1: one-cycle pulse; a multi-button press was rejected.
- `overflow`, out, 1: sticky; some tally or the total hit saturation.
- `counts`, out, NUM_CAND*CNT_W: tallies; candidate i occupies bits [i*CNT_W +: CNT_W].
- `total_votes`, out, TOT_W: accepted votes, saturating.
- `polls_closed`, out, 1: high in the SCAN and DONE states.
- `result_valid`, out, 1: high in the DONE state.
- `winner`, out, IDX_W: lowest index holding the maximum tally; valid when `result_valid` is high.
- `tie`, out, 1: two or more candidates share the maximum; valid when `result_valid` is high.

## Operation
- Reset value of every output and internal register is 0, including `vote_q`. The state resets to IDLE.
- Edge detect: `vote_q` registers `vote` every cycle. `press = vote & ~vote_q`.
- Only rising edges count. A button already held when the ballot is armed must be released and pressed again.
- States: IDLE, ARMED, SCAN, DONE.
- IDLE:
  - `ballot_open` -> ARMED.
  - Presses are ignored.
- ARMED:
  - `ready` = 1.
  - Exactly one bit of `press` set: increment that tally and `total_votes`, pulse `vote_ack`, go to IDLE.
  - Two or more bits of `press` set: pulse `invalid`, no count, stay in ARMED.
  - `ballot_open` while in ARMED is ignored; ballots do not accumulate.
- `close_polls` in IDLE or ARMED -> SCAN. An armed ballot is discarded.
- `close_polls` has priority over a press in the same cycle; that press is not counted.
- SCAN:
  - Visits indices 0..NUM_CAND-1, one per cycle, tracking `max` and `win_idx`.
  - Index 0 initialises `max` and `win_idx`, and clears `tie`.
  - tally > `max`: update `max` and `win_idx`, clear `tie`.
  - tally == `max` (index > 0): set `tie`.
  - `winner` and `tie` are driven from these scan registers.
  - After the last index, go to DONE.
- DONE: terminal state. Only `rst` leaves it. `ballot_open`, `vote` and `close_polls` are ignored.
- Saturation:
  - A tally at 2^CNT_W-1 holds its value. `vote_ack` still pulses, and `overflow` is set.
  - `total_votes` saturates independently at 2^TOT_W-1, and also sets `overflow`.
- All-zero tallies give `winner` = 0 and `tie` = 1.
- Reset asserted mid-ballot or mid-scan clears everything immediately, since reset is asynchronous.

## Timing
- Press counted when `vote` rises in cycle t while ARMED:
  - Tally, `total_votes` and `vote_ack` are updated at edge t+1.
  - `ready` falls at edge t+1.
  - Latency: one clock from the sampled press.
- `ballot_open` sampled at edge t: `ready` = 1 from t+1. A press sampled at t+1 is accepted.
- `close_polls` sampled at edge t:
  - `polls_closed` = 1 from t+1.
  - Scan occupies edges t+1..t+NUM_CAND.
  - `result_valid` = 1 from edge t+NUM_CAND+1 and stays high.
- `invalid` and `vote_ack` are never high in the same cycle.

## Test plan
- Reset, then 3x (`ballot_open`, press `vote`=0001) with NUM_CAND=4 -> `counts`[0]=3, `total_votes`=3, three `vote_ack` pulses, `ready` low after each.
- Press `vote`=0010 with no ballot, then hold it through `ballot_open` -> no count. Release and re-press -> `counts`[1]=1.
- Armed, press `vote`=0110 -> `invalid` pulse, still ARMED. Then press 0100 -> `counts`[2]=1.
- CNT_W=2: 5 accepted votes for candidate 0 -> `counts`[0]=3, `total_votes`=5, `overflow`=1, 5 acks.
- Tallies {2,5,5,1}, then `close_polls` -> `result_valid` exactly NUM_CAND+1 cycles later, `winner`=1, `tie`=1. Later `ballot_open` and presses are ignored.
- ARMED with `close_polls` and a press in the same cycle -> press not counted, SCAN entered. Reset asserted during SCAN -> all outputs 0, state IDLE.
